// File: rtl/AHB_pkg.sv
// Shared AHB-Lite definitions: width constants, bus encodings,
// SRAM slave FSM states and transfer-decode helpers.
package AHB_pkg;

  localparam int AHB_HTRANS_W = 2;
  localparam int AHB_HSIZE_W  = 3;
  localparam int AHB_HBURST_W = 3;
  localparam int AHB_HPROT_W  = 4;
  localparam int AHB_BE_W     = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } HTRANS_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } HSIZE_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } HRESP_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } sram_state_e;

  // Size and alignment legality of one transfer.
  function automatic logic size_ok(
    input logic [2:0] sz,
    input logic [1:0] lo
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (sz == HSIZE_BYTE): ok = 1'b1;
      (sz == HSIZE_HALF): ok = ~lo[0];
      (sz == HSIZE_WORD): ok = (lo == 2'b00);
      (sz > HSIZE_WORD):  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Little-endian byte lanes touched by a transfer.
  function automatic logic [AHB_BE_W-1:0] byte_en(
    input logic [2:0] sz,
    input logic [1:0] lo
  );
    logic [AHB_BE_W-1:0] be;
    be = '0;
    unique case (1'b1)
      (sz == HSIZE_BYTE): be = 4'b0001 << lo;
      (sz == HSIZE_HALF): be = lo[1] ? 4'b1100 : 4'b0011;
      (sz == HSIZE_WORD): be = 4'b1111;
      (sz > HSIZE_WORD):  be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_lite_sram_bank.sv
// Byte-enable RAM: one synchronous write port, one async read port.
// Ports: clk, i_we, i_be, i_waddr, i_wdata, i_raddr -> o_rdata.
module ahb_lite_sram_bank #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [DW/8-1:0] i_be,
  input  logic [AW-1:0]   i_waddr,
  input  logic [DW-1:0]   i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [DW-1:0]   o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and
// two-cycle ERROR response for out-of-range or misaligned transfers.
// Ports: clk, HRESETn_global, HSEL, HADDR, HTRANS, HWRITE, HSIZE,
//   HBURST, HPROT, HWDATA, HREADY -> HREADYOUT, HRESP, HRDATA.
module ahb_lite_sram_slave
  import AHB_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    HRESETn_global,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [AHB_HTRANS_W-1:0] HTRANS,
  input  logic                    HWRITE,
  input  logic [AHB_HSIZE_W-1:0]  HSIZE,
  input  logic [AHB_HBURST_W-1:0] HBURST,
  input  logic [AHB_HPROT_W-1:0]  HPROT,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA
);

  localparam int IDX_W =
    (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  sram_state_e r_state;
  sram_state_e w_state_n;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_n;

  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_write;
  logic [AHB_HSIZE_W-1:0] r_size;
  logic                   r_pend;

  logic                  w_open;
  logic                  w_accept;
  logic                  w_range_err;
  logic                  w_illegal;
  logic                  w_done;
  logic                  w_we;
  logic [AHB_BE_W-1:0]   w_be;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  // Only ST_IDLE and ST_ERR2 drive HREADYOUT high, so only they
  // may sample a new address phase.
  assign w_open = (r_state == ST_IDLE) ||
                  (r_state == ST_ERR2);

  assign w_accept = w_open && HSEL && HREADY && HTRANS[1];

  assign w_range_err =
    ({2'b00, HADDR[ADDR_WIDTH-1:2]} >=
     ADDR_WIDTH'(MEM_DEPTH));

  assign w_illegal = w_range_err ||
                     !size_ok(HSIZE, HADDR[1:0]);

  // A legal transfer finishes its data phase in the first
  // ST_IDLE cycle after acceptance (and any wait states).
  assign w_done = (r_state == ST_IDLE) && r_pend;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    unique case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (r_state == ST_ERR2) begin
          HRESP = HRESP_ERROR;
        end
        w_state_n = ST_IDLE;
        if (w_accept) begin
          if (w_illegal) begin
            w_state_n = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_n = ST_WAIT;
            w_cnt_n   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (r_cnt == 2'd0) begin
          w_state_n = ST_IDLE;
        end else begin
          w_cnt_n = r_cnt - 2'd1;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        w_state_n = ST_ERR2;
      end
    endcase
  end

  always_ff @(posedge clk or negedge HRESETn_global) begin
    if (!HRESETn_global) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Clearing r_pend on reset is what drops an in-flight write.
  always_ff @(posedge clk or negedge HRESETn_global) begin
    if (!HRESETn_global) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_pend  <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= HADDR;
      r_write <= HWRITE;
      r_size  <= HSIZE;
      r_pend  <= !w_illegal;
    end else if (w_done) begin
      r_pend  <= 1'b0;
    end
  end

  assign w_idx = r_addr[IDX_W+1:2];
  assign w_be  = byte_en(r_size, r_addr[1:0]);
  assign w_we  = w_done && r_write;

  ahb_lite_sram_bank #(
    .DEPTH (MEM_DEPTH),
    .AW    (IDX_W),
    .DW    (DATA_WIDTH)
  ) u_bank (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_waddr (w_idx),
    .i_wdata (HWDATA),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  assign HRDATA = (w_done && !r_write) ? w_rdata : '0;

  assign w_unused = ^{HBURST, HPROT, HTRANS[0],
                      r_addr[ADDR_WIDTH-1:IDX_W+2]};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: one instance with one
// wait state, one zero-wait instance, hand-computed expectations.
module tb_ahb_lite_sram_slave;

  logic        clk;
  logic        rst_n;
  logic        sel1;
  logic        sel0;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;

  logic        hout1;
  logic        hresp1;
  logic [31:0] hrdata1;
  logic        hout0;
  logic        hresp0;
  logic [31:0] hrdata0;

  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-slave bus: HREADY is the slave's own HREADYOUT.
  ahb_lite_sram_slave #(
    .WAIT_STATES (1)
  ) dut1 (
    .clk            (clk),
    .HRESETn_global (rst_n),
    .HSEL           (sel1),
    .HADDR          (haddr),
    .HTRANS         (htrans),
    .HWRITE         (hwrite),
    .HSIZE          (hsize),
    .HBURST         (hburst),
    .HPROT          (hprot),
    .HWDATA         (hwdata),
    .HREADY         (hout1),
    .HREADYOUT      (hout1),
    .HRESP          (hresp1),
    .HRDATA         (hrdata1)
  );

  ahb_lite_sram_slave #(
    .WAIT_STATES (0)
  ) dut0 (
    .clk            (clk),
    .HRESETn_global (rst_n),
    .HSEL           (sel0),
    .HADDR          (haddr),
    .HTRANS         (htrans),
    .HWRITE         (hwrite),
    .HSIZE          (hsize),
    .HBURST         (hburst),
    .HPROT          (hprot),
    .HWDATA         (hwdata),
    .HREADY         (hout0),
    .HREADYOUT      (hout0),
    .HRESP          (hresp0),
    .HRDATA         (hrdata0)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    sel1   = 1'b0;
    sel0   = 1'b0;
    htrans = 2'd0;
  endtask

  task automatic addr_ph(
    input logic        w,
    input logic [31:0] a,
    input logic [2:0]  sz
  );
    htrans = 2'd2;
    hwrite = w;
    haddr  = a;
    hsize  = sz;
  endtask

  // One non-overlapped transfer on the one-wait-state slave.
  task automatic t1(
    input string       tag,
    input logic        w,
    input logic [31:0] a,
    input logic [2:0]  sz,
    input logic [31:0] wd,
    input logic        err,
    input logic [31:0] exp_rd
  );
    sel1 = 1'b1;
    addr_ph(w, a, sz);
    nxt();
    bus_idle();
    hwdata = wd;
    if (!err) begin
      chk({tag, ".wait_rdy"}, 32'(hout1), 32'd0);
      chk({tag, ".wait_resp"}, 32'(hresp1), 32'd0);
      nxt();
      chk({tag, ".rdy"}, 32'(hout1), 32'd1);
      chk({tag, ".resp"}, 32'(hresp1), 32'd0);
      chk({tag, ".rdata"}, hrdata1, w ? 32'd0 : exp_rd);
      nxt();
    end else begin
      chk({tag, ".e1_rdy"}, 32'(hout1), 32'd0);
      chk({tag, ".e1_resp"}, 32'(hresp1), 32'd1);
      chk({tag, ".e1_rdata"}, hrdata1, 32'd0);
      nxt();
      chk({tag, ".e2_rdy"}, 32'(hout1), 32'd1);
      chk({tag, ".e2_resp"}, 32'(hresp1), 32'd1);
      chk({tag, ".e2_rdata"}, hrdata1, 32'd0);
      nxt();
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = 3'd2;
    hburst = 3'd0;
    hprot  = 4'b0011;
    hwdata = '0;
    bus_idle();

    #12;
    chk("rst.rdy", 32'(hout1), 32'd1);
    chk("rst.resp", 32'(hresp1), 32'd0);
    chk("rst.rdata", hrdata1, 32'd0);
    chk("rst0.rdy", 32'(hout0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    nxt();

    t1("w10", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
    t1("r10", 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF);

    t1("w10z", 1'b1, 32'h10, 3'd2, 32'h0, 1'b0, 32'h0);
    t1("wb13", 1'b1, 32'h13, 3'd0, 32'hAA000000, 1'b0, 32'h0);
    t1("rb10", 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hAA000000);

    t1("w14", 1'b1, 32'h14, 3'd2, 32'h11223344, 1'b0, 32'h0);
    t1("wh16", 1'b1, 32'h16, 3'd1, 32'hBEEF0000, 1'b0, 32'h0);
    t1("rh14", 1'b0, 32'h14, 3'd2, 32'h0, 1'b0, 32'hBEEF3344);

    t1("r402", 1'b0, 32'h402, 3'd2, 32'h0, 1'b1, 32'h0);
    t1("r10b", 1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hAA000000);

    t1("w0", 1'b1, 32'h0, 3'd2, 32'h01020304, 1'b0, 32'h0);
    t1("w400", 1'b1, 32'h400, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0);
    t1("r0", 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 32'h01020304);
    t1("w3fc", 1'b1, 32'h3FC, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0);
    t1("r3fc", 1'b0, 32'h3FC, 3'd2, 32'h0, 1'b0, 32'hCAFEF00D);

    t1("w20", 1'b1, 32'h20, 3'd2, 32'h55667788, 1'b0, 32'h0);
    t1("wh21", 1'b1, 32'h21, 3'd1, 32'hFFFFFFFF, 1'b1, 32'h0);
    t1("wsz3", 1'b1, 32'h20, 3'd3, 32'hFFFFFFFF, 1'b1, 32'h0);
    t1("r20", 1'b0, 32'h20, 3'd2, 32'h0, 1'b0, 32'h55667788);

    // New transfer accepted in the second ERROR cycle.
    sel1 = 1'b1;
    addr_ph(1'b0, 32'h21, 3'd1);
    nxt();
    bus_idle();
    chk("e2acc.e1_rdy", 32'(hout1), 32'd0);
    nxt();
    chk("e2acc.e2_resp", 32'(hresp1), 32'd1);
    sel1 = 1'b1;
    addr_ph(1'b0, 32'h20, 3'd2);
    nxt();
    bus_idle();
    chk("e2acc.wait_rdy", 32'(hout1), 32'd0);
    chk("e2acc.wait_resp", 32'(hresp1), 32'd0);
    nxt();
    chk("e2acc.rdy", 32'(hout1), 32'd1);
    chk("e2acc.rdata", hrdata1, 32'h55667788);
    nxt();

    // BUSY while selected, then NONSEQ while deselected.
    sel1 = 1'b1;
    addr_ph(1'b1, 32'h20, 3'd2);
    htrans = 2'd1;
    nxt();
    hwdata = 32'h0;
    chk("busy.rdy", 32'(hout1), 32'd1);
    chk("busy.resp", 32'(hresp1), 32'd0);
    sel1   = 1'b0;
    htrans = 2'd2;
    nxt();
    chk("nsel.rdy", 32'(hout1), 32'd1);
    bus_idle();
    nxt();
    t1("r20c", 1'b0, 32'h20, 3'd2, 32'h0, 1'b0, 32'h55667788);

    // Reset in the wait state of a write must drop it.
    t1("w40", 1'b1, 32'h40, 3'd2, 32'h0BADCAFE, 1'b0, 32'h0);
    sel1 = 1'b1;
    addr_ph(1'b1, 32'h40, 3'd2);
    nxt();
    bus_idle();
    hwdata = 32'h11111111;
    chk("rstw.wait_rdy", 32'(hout1), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw.rdy", 32'(hout1), 32'd1);
    chk("rstw.resp", 32'(hresp1), 32'd0);
    chk("rstw.rdata", hrdata1, 32'd0);
    nxt();
    rst_n = 1'b1;
    nxt();
    t1("r40", 1'b0, 32'h40, 3'd2, 32'h0, 1'b0, 32'h0BADCAFE);

    // Zero-wait slave: pipelined write then read of 0x30.
    sel0 = 1'b1;
    addr_ph(1'b1, 32'h30, 3'd2);
    nxt();
    hwdata = 32'h12345678;
    addr_ph(1'b0, 32'h30, 3'd2);
    chk("z.w_rdy", 32'(hout0), 32'd1);
    chk("z.w_resp", 32'(hresp0), 32'd0);
    nxt();
    bus_idle();
    chk("z.r_rdy", 32'(hout0), 32'd1);
    chk("z.r_rdata", hrdata0, 32'h12345678);
    nxt();
    chk("z.after_rdata", hrdata0, 32'd0);

    sel0 = 1'b1;
    addr_ph(1'b0, 32'h402, 3'd2);
    nxt();
    bus_idle();
    chk("z.e1_rdy", 32'(hout0), 32'd0);
    chk("z.e1_resp", 32'(hresp0), 32'd1);
    nxt();
    chk("z.e2_rdy", 32'(hout0), 32'd1);
    chk("z.e2_resp", 32'(hresp0), 32'd1);
    chk("z.e2_rdata", hrdata0, 32'd0);
    nxt();
    chk("z.idle_resp", 32'(hresp0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
